sum_result_fifo: RTL and testbench

Downstream stage of the 12-bit operand adder: captures each single-cycle `valid`/`y` result pulse into a small FIFO and presents results to a consumer through a valid/ready handshake. It keeps a running accumulator of accepted sums, with a sticky overflow flag, and counts results dropped because the FIFO was full. The adder has no backpressure, so this block is where results get decoupled from a stalling consumer.

---
 rtl/sum_pkg.sv | 12 +
 rtl/sum_fifo_core.sv | 56 +++++
 rtl/sum_result_fifo.sv | 74 +++++++
 tb/tb_sum_result_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared widths, types and constants for the adder result FIFO stage.
package sum_pkg;

    localparam int unsigned SUM_W     = 12;
    localparam int unsigned SUM_ACC_W = 16;
    localparam int unsigned DROP_W    = 8;

    typedef logic [SUM_W-1:0] sum_t;

    localparam logic [DROP_W-1:0] DROP_CNT_MAX = DROP_W'(255);

endpackage

// File: rtl/sum_fifo_core.sv
// Circular FIFO storage: memory array, read/write pointers and occupancy count.
module sum_fifo_core
    import sum_pkg::*;
#(
    parameter int unsigned W     = SUM_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wr_data,
    output logic [W-1:0]                 rd_data_c,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is not reset; the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data_c = mem[rd_ptr];
    assign full_c    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sum_result_fifo.sv
// Decouples adder results from a stalling consumer; tracks running sum, overflow and drops.
module sum_result_fifo
    import sum_pkg::*;
#(
    parameter int unsigned W     = SUM_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ACC_W = SUM_ACC_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [W-1:0]                 in_y,
    input  logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ACC_W-1:0]             acc,
    output logic                         acc_ovf,
    output logic [DROP_W-1:0]            drop_cnt
);

    localparam int unsigned ACC_SUM_W = ACC_W + 1;

    logic                 full_c;
    logic                 pop_c;
    logic                 push_c;
    logic                 drop_c;
    logic [ACC_SUM_W-1:0] acc_sum_c;

    assign out_valid = (count != '0);
    assign pop_c     = out_valid && out_ready;
    assign push_c    = in_valid && (!full_c || pop_c);
    assign drop_c    = in_valid && full_c && !pop_c;
    assign acc_sum_c = {1'b0, acc} + ACC_SUM_W'(in_y);

    sum_fifo_core #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .pop       (pop_c),
        .wr_data   (in_y),
        .rd_data_c (out_data),
        .count     (count),
        .full_c    (full_c)
    );

    // Clear takes priority but still absorbs a coincident push or drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            acc_ovf  <= 1'b0;
            drop_cnt <= '0;
        end else if (acc_clr) begin
            acc      <= push_c ? ACC_W'(in_y) : '0;
            acc_ovf  <= 1'b0;
            drop_cnt <= drop_c ? DROP_W'(1) : '0;
        end else begin
            if (push_c) begin
                acc <= acc_sum_c[ACC_W-1:0];
                if (acc_sum_c[ACC_W]) begin
                    acc_ovf <= 1'b1;
                end
            end
            if (drop_c && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sum_result_fifo.sv
// Randomized and directed bench for sum_result_fifo with a queue-based reference model and scoreboard.
module tb_sum_result_fifo;

    localparam int unsigned W     = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ACC_W = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_y;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    count;
    logic [15:0]   acc;
    logic          acc_ovf;
    logic [7:0]    drop_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int unsigned model_q[$];
    int unsigned exp_q[$];
    int unsigned model_acc;
    int unsigned model_ovf;
    int unsigned model_drop;

    sum_result_fifo #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_y      (in_y),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .acc       (acc),
        .acc_ovf   (acc_ovf),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each handshake must deliver the oldest accepted result.
    initial begin
        int unsigned e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected act=%0h exp=none t=%0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_data", 32'(out_data), e);
                end
            end
        end
    end

    task automatic check_state();
        chk("count", 32'(count), model_q.size());
        chk("out_valid", 32'(out_valid), (model_q.size() != 0) ? 1 : 0);
        chk("acc", 32'(acc), model_acc);
        chk("acc_ovf", 32'(acc_ovf), model_ovf);
        chk("drop_cnt", 32'(drop_cnt), model_drop);
        if (model_q.size() != 0) begin
            chk("head", 32'(out_data), model_q[0]);
        end
    endtask

    // Drive one cycle (called just after a rising edge), advance the model, check after the edge.
    task automatic cycle(input logic v, input int unsigned y, input logic rdy, input logic clr);
        bit pop, full, push, drop;
        in_valid  = v;
        in_y      = W'(y);
        out_ready = rdy;
        acc_clr   = clr;
        y         = y % (1 << W);
        pop  = rdy && (model_q.size() != 0);
        full = (model_q.size() == DEPTH);
        push = v && (!full || pop);
        drop = v && full && !pop;
        if (pop) void'(model_q.pop_front());
        if (push) begin
            model_q.push_back(y);
            exp_q.push_back(y);
        end
        if (clr) begin
            model_acc  = push ? y : 0;
            model_ovf  = 0;
            model_drop = drop ? 1 : 0;
        end else begin
            if (push) begin
                model_acc = model_acc + y;
                if (model_acc >= (1 << ACC_W)) begin
                    model_acc = model_acc - (1 << ACC_W);
                    model_ovf = 1;
                end
            end
            if (drop && model_drop < 255) model_drop++;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        model_acc  = 0;
        model_ovf  = 0;
        model_drop = 0;
    endtask

    initial begin
        int unsigned max_cnt;
        int unsigned bias;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_y      = '0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // three results through an always-ready consumer
        max_cnt = 0;
        cycle(1, 'h005, 1, 0); if (count > max_cnt) max_cnt = count;
        cycle(1, 'h3FF, 1, 0); if (count > max_cnt) max_cnt = count;
        cycle(1, 'h200, 1, 0); if (count > max_cnt) max_cnt = count;
        cycle(0, 0, 1, 0);
        chk("acc_three", 32'(acc), 'h0604);
        chk("max_count_one", max_cnt, 1);

        // stalled consumer: six strobes, two dropped
        cycle(0, 0, 1, 1);
        for (int i = 1; i <= 6; i++) cycle(1, i, 0, 0);
        chk("stall_count", 32'(count), 4);
        chk("stall_drop", 32'(drop_cnt), 2);
        chk("stall_acc", 32'(acc), 10);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        chk("drained", 32'(count), 0);

        // full with simultaneous pop and push
        for (int i = 0; i < 4; i++) cycle(1, 'h10 + i, 0, 0);
        cycle(1, 'h0AA, 1, 0);
        chk("full_pop_push_count", 32'(count), 4);
        chk("full_pop_push_drop", 32'(drop_cnt), 2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        chk("aa_head", 32'(out_data), 'h0AA);
        cycle(0, 0, 1, 0);

        // accumulator wrap and sticky overflow
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) cycle(1, 'hFFF, 1, 0);
        cycle(0, 0, 1, 0);
        chk("wrap_acc", 32'(acc), 'h0FEF);
        chk("wrap_ovf", 32'(acc_ovf), 1);
        cycle(0, 0, 1, 1);
        chk("clr_acc", 32'(acc), 0);
        chk("clr_ovf", 32'(acc_ovf), 0);

        // drop counter saturation
        for (int i = 0; i < 265; i++) cycle(1, i, 0, 0);
        chk("drop_sat", 32'(drop_cnt), 255);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // asynchronous reset while holding three entries with five drops
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(1, 'h40 + i, 0, 0);
        cycle(0, 0, 1, 0);
        chk("pre_rst_count", 32'(count), 3);
        chk("pre_rst_drop", 32'(drop_cnt), 5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        acc_clr   = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 'h155, 0, 0);
        chk("post_rst_head", 32'(out_data), 'h155);
        cycle(0, 0, 1, 0);

        // clear coincident with a push
        cycle(1, 'h123, 0, 1);
        chk("clr_push_acc", 32'(acc), 'h0123);
        chk("clr_push_head", 32'(out_data), 'h123);
        cycle(0, 0, 1, 0);

        // randomized traffic with varying consumer stall rates
        for (int blk = 0; blk < 20; blk++) begin
            bias = $urandom_range(0, 3);
            for (int i = 0; i < 100; i++) begin
                cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) < bias + 1),
                      ($urandom_range(0, 63) == 0));
            end
        end

        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 1, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
